// File: rtl/puerto_serie.sv
// puerto_serie: memory-mapped UART transmitter with TX FIFO and status register
// Ports: clk, reset (async, active-high); addr/datain/MW CPU store bus;
//        dataout status read {ocupado, desbordado, lleno, vacio} at DIRECCION+1;
//        tx serial line (idle high); ocupado frame in flight or FIFO non-empty.
// Optional: define PUERTO_SERIE_PARIDAD_EN to append an even-parity bit.
module puerto_serie #(
  parameter logic [15:0] DIRECCION = 16'hFF00,
  parameter int DIVISOR = 16,
  parameter int PROFUNDIDAD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] datain,
  input  logic        MW,
  output logic [15:0] dataout,
  output logic        tx,
  output logic        ocupado
);
  localparam int PW = $clog2(PROFUNDIDAD);
  localparam logic [15:0] DIR_ST = DIRECCION + 16'd1;
  localparam logic [15:0] FIN_BAUD = 16'(DIVISOR - 1);
`ifdef PUERTO_SERIE_PARIDAD_EN
  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARIDAD, PARADA} estado_t;
`else
  typedef enum logic [1:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;
`endif
  estado_t estado_q, estado_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic desbordado_q, desbordado_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [7:0] mem_q [PROFUNDIDAD];
  logic vacio, lleno, push_req, clr_req, pop, push, fin;
  logic unused_datain;
`ifdef PUERTO_SERIE_PARIDAD_EN
  logic par_q, par_d;
`endif
  assign unused_datain = ^datain[15:8];
  assign vacio = cnt_q == '0;
  assign lleno = cnt_q == (PW+1)'(PROFUNDIDAD);
  assign push_req = MW && addr == DIRECCION;
  assign clr_req = MW && addr == DIR_ST && datain[0];
  assign pop = estado_q == REPOSO && !vacio;
  // a pop in the same cycle frees a slot, so a push into a full FIFO still fits
  assign push = push_req && (!lleno || pop);
  assign fin = baud_q == FIN_BAUD;
  assign ocupado = estado_q != REPOSO || !vacio;
  assign tx = tx_q;
  assign dataout = addr == DIR_ST ? {12'b0, ocupado, desbordado_q, lleno, vacio} : 16'h0000;
  always_comb begin
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    desbordado_d = clr_req ? 1'b0 : desbordado_q | (push_req && !push);
  end
  always_comb begin
    estado_d = estado_q;
    baud_d = fin ? 16'd0 : baud_q + 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
`ifdef PUERTO_SERIE_PARIDAD_EN
    par_d = pop ? ^mem_q[rd_q] : par_q;
`endif
    case (estado_q)
      REPOSO: begin
        baud_d = 16'd0;
        if (!vacio) begin
          estado_d = INICIO;
          shift_d = mem_q[rd_q];
        end
      end
      INICIO: estado_d = fin ? DATOS : INICIO;
      DATOS: if (fin) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
`ifdef PUERTO_SERIE_PARIDAD_EN
        estado_d = bit_q == 3'd7 ? PARIDAD : DATOS;
`else
        estado_d = bit_q == 3'd7 ? PARADA : DATOS;
`endif
      end
`ifdef PUERTO_SERIE_PARIDAD_EN
      PARIDAD: estado_d = fin ? PARADA : PARIDAD;
`endif
      PARADA: estado_d = fin ? REPOSO : PARADA;
      default: estado_d = REPOSO;
    endcase
    // tx is registered from the next state so the line changes exactly on the edge
    tx_d = estado_d != INICIO && (estado_d != DATOS || shift_d[0]);
`ifdef PUERTO_SERIE_PARIDAD_EN
    if (estado_d == PARIDAD) tx_d = par_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= datain[7:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= REPOSO;
      baud_q <= 16'd0;
      bit_q <= 3'd0;
      shift_q <= 8'd0;
      tx_q <= 1'b1;
      desbordado_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      estado_q <= estado_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      desbordado_q <= desbordado_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef PUERTO_SERIE_PARIDAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_puerto_serie.sv
// tb_puerto_serie: scoreboard bench for puerto_serie with a serial-line receiver monitor
module tb_puerto_serie;
  localparam int DIV = 4;
`ifdef PUERTO_SERIE_PARIDAD_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MW = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] datain = 16'h0;
  logic [15:0] dataout;
  logic tx, ocupado;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic rst_seen = 1'b0;
  puerto_serie #(.DIRECCION(16'hFF00), .DIVISOR(DIV), .PROFUNDIDAD(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .MW(MW),
    .dataout(dataout), .tx(tx), .ocupado(ocupado)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic m);
    addr = a;
    datain = d;
    MW = m;
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus(a, d, 1'b1);
    tick;
    bus(16'h0, 16'h0, 1'b0);
  endtask
  task automatic rd_status(input string nm, input logic [15:0] e);
    addr = 16'hFF01;
    #1;
    chk(nm, dataout, e);
    addr = 16'h0;
  endtask
  task automatic wait_idle(input string nm);
    int i = 0;
    while (ocupado && i < 3000) begin
      tick;
      i++;
    end
    chk(nm, ocupado, 0);
    repeat (3) tick;
  endtask
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int s;
    s = k / DIV;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (FL == 11 && s == 9) return ^b;
    return 1'b1;
  endfunction
  initial forever begin
    @(posedge reset);
    rst_seen = 1'b1;
  end
  initial begin
    logic [7:0] b;
    logic st, stp, par, e_par;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset || tx) continue;
      rst_seen = 1'b0;
      par = 1'b0;
      repeat (2) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx;
      end
      if (FL == 11) begin
        repeat (DIV) @(negedge clk);
        par = tx;
      end
      repeat (DIV) @(negedge clk);
      stp = tx;
      if (rst_seen) continue;
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", {56'h0, b}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        e_par = (FL == 11) ? ^e : 1'b0;
        chk("frame_start", st, 0);
        chk("frame_data", b, e);
        chk("frame_parity", par, e_par);
        chk("frame_stop", stp, 1);
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] wt, we, wo, wo_e;
    logic bad;
    bus(16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_ocupado", ocupado, 0);
    rd_status("reset_status", 16'h0001);
    reset = 1'b0;
    tick;
    chk("idle_tx", tx, 1);
    exp_q.push_back(8'h55);
    wr(16'hFF00, 16'h0055);
    chk("latency_tx_still_idle", tx, 1);
    chk("ocupado_after_write", ocupado, 1);
    wt = '0;
    we = '0;
    wo = '0;
    for (int k = 0; k < FL*DIV; k++) begin
      tick;
      wt[k] = tx;
      wo[k] = ocupado;
      we[k] = frame_bit(8'h55, k);
    end
    wo_e = (64'd1 << (FL*DIV)) - 64'd1;
    chk("waveform_55", wt, we);
    chk("ocupado_during_frame", wo, wo_e);
    tick;
    chk("ocupado_after_stop", ocupado, 0);
    chk("tx_after_stop", tx, 1);
    wait_idle("idle_after_55");
    wr(16'hFEFF, 16'h00AA);
    wr(16'hFF02, 16'h00AA);
    bad = 1'b0;
    repeat (12) begin
      tick;
      if (tx !== 1'b1 || ocupado !== 1'b0) bad = 1'b1;
    end
    chk("other_addr_no_effect", bad, 0);
    addr = 16'hFEFF;
    #1;
    chk("dataout_FEFF", dataout, 16'h0000);
    addr = 16'hFF02;
    #1;
    chk("dataout_FF02", dataout, 16'h0000);
    addr = 16'hFF00;
    #1;
    chk("dataout_FF00", dataout, 16'h0000);
    rd_status("status_after_other", 16'h0001);
    for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    for (int v = 1; v <= 6; v++) begin
      bus(16'hFF00, {8'hA5, 8'(v)}, 1'b1);
      tick;
    end
    bus(16'h0, 16'h0, 1'b0);
    rd_status("status_full_overflow", 16'h000E);
    repeat (50) tick;
    rd_status("status_overflow_tx", 16'h000C);
    wr(16'hFF01, 16'hFFFE);
    rd_status("status_clear_bit0_zero", 16'h000C);
    wr(16'hFF01, 16'h0001);
    rd_status("status_after_clear", 16'h0008);
    wait_idle("idle_after_burst");
    rd_status("status_idle_burst", 16'h0001);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h40);
    bus(16'hFF00, 16'h0007, 1'b1);
    tick;
    bus(16'hFF00, 16'h0003, 1'b1);
    tick;
    bus(16'hFF00, 16'h0010, 1'b1);
    tick;
    bus(16'hFF00, 16'h0020, 1'b1);
    tick;
    bus(16'hFF00, 16'h0030, 1'b1);
    tick;
    bus(16'h0, 16'h0, 1'b0);
    rd_status("status_full_no_ovf", 16'h000A);
    repeat (FL*DIV - 3) tick;
    wr(16'hFF00, 16'h0040);
    rd_status("status_push_with_pop", 16'h000A);
    wait_idle("idle_after_push_pop");
    rd_status("status_idle_push_pop", 16'h0001);
    exp_q.push_back(8'h5A);
    wr(16'hFF00, 16'h005A);
    repeat (14) tick;
    chk("tx_mid_datos", tx, 0);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("reset_async_tx", tx, 1);
    chk("reset_async_ocupado", ocupado, 0);
    rd_status("reset_async_status", 16'h0001);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 1'b0;
    repeat (60) begin
      tick;
      if (tx !== 1'b1 || ocupado !== 1'b0) bad = 1'b1;
    end
    chk("silent_after_reset", bad, 0);
    rd_status("status_after_reset", 16'h0001);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/puerto_serie.md
PUERTO_SERIE -- requirements
Module: puerto_serie

Interface
REQ-001 SHALL have parameter DIRECCION, default 16'hFF00, the memory-mapped address of the TX data register; the status register is at DIRECCION+1.
REQ-002 SHALL have parameter DIVISOR, default 16, the number of clk cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have parameter PROFUNDIDAD, default 4, the number of TX FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr  input  16  CPU address bus (the bus driving RAM address).
REQ-007 datain  input  16  CPU store data bus (the bus driving RAM write data).
REQ-008 MW  input  1  CPU memory-write strobe, active-high.
REQ-009 dataout  output  16  status register read value, valid combinationally when addr==DIRECCION+1, else 16'h0000.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 ocupado  output  1  high while a frame is being shifted or the FIFO is non-empty.

Function
REQ-012 Data write: MW=1 and addr==DIRECCION at a rising edge SHALL push datain[7:0] into the FIFO; datain[15:8] is ignored.
REQ-013 A push while the FIFO is full SHALL be dropped and SHALL set the sticky flag desbordado; if a pop occurs in the same cycle, the push SHALL be accepted and desbordado is unchanged.
REQ-014 Status write: MW=1 and addr==DIRECCION+1 with datain[0]=1 SHALL clear desbordado; no other effect.
REQ-015 Writes to any other address SHALL have no effect.
REQ-016 dataout at DIRECCION+1 SHALL be {12'b0, ocupado, desbordado, lleno, vacio}.
REQ-017 TX FSM states: REPOSO, INICIO, DATOS, PARADA (plus PARIDAD, see REQ-026).
REQ-018 REPOSO: tx=1; if FIFO non-empty, pop head into the shift register and go to INICIO on the same edge.
REQ-019 INICIO: tx=0 for DIVISOR cycles, then DATOS.
REQ-020 DATOS: 8 bits, LSB first, each for DIVISOR cycles; a 3-bit bit counter wraps 7->0 on exit; then PARADA.
REQ-021 PARADA: tx=1 for DIVISOR cycles; then REPOSO, which pops the next byte on the following edge if one is available (one REPOSO cycle between frames).
REQ-022 Latency: a write at edge N into an empty FIFO with the FSM in REPOSO SHALL drive tx=0 starting after edge N+1.
REQ-023 Frame length SHALL be exactly 10*DIVISOR cycles without parity and 11*DIVISOR cycles with parity.
REQ-024 tx SHALL be driven from a register (glitch-free).

Reset
REQ-025 While reset=1, asynchronously: tx=1, ocupado=0, FIFO empty (pointers and count 0), desbordado=0, FSM=REPOSO, baud and bit counters 0; a frame in progress SHALL be abandoned and its byte discarded.

Configuration
REQ-026 Macro PUERTO_SERIE_PARIDAD_EN: when defined, the FSM SHALL insert state PARIDAD between DATOS and PARADA, driving tx = XOR of the 8 data bits (even parity) for DIVISOR cycles; when undefined, no PARIDAD state exists and DATOS goes directly to PARADA.

Verification
REQ-027 DIVISOR=4, write 16'h0055 to FF00 -> tx: 0 x4, then 1,0,1,0,1,0,1,0 each x4, then 1 x4 (40 cycles); ocupado=1 throughout, 0 one cycle after the stop bit ends.
REQ-028 PROFUNDIDAD=4, six back-to-back writes 0x01..0x06 on consecutive cycles -> frames 0x01..0x05 sent in order, 0x06 lost, status read at FF01 = 16'h000C during transmission.
REQ-029 Write 16'h0001 to FF01 after REQ-028 -> desbordado=0; status during transmission reads 16'h0008.
REQ-030 Assert reset for 1 cycle in mid-DATOS -> tx=1 immediately, without waiting for a clk edge; FIFO empty; status 16'h0001; no further frames.
REQ-031 With PUERTO_SERIE_PARIDAD_EN, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; frame 44 cycles at DIVISOR=4.
REQ-032 Write 0xAA to FEFF and to FF02 -> tx stays 1, ocupado stays 0, dataout=0 when addr is not FF01.
